spc_cfg_receiver: RTL

SPC_CFG_RECEIVER -- requirements
Module: spc_cfg_receiver

---
 rtl/spc_cfg_receiver_if.sv | 29 ++
 rtl/spc_cfg_receiver.sv | 79 +++++++
 2 files changed

// File: rtl/spc_cfg_receiver_if.sv
// Serial configuration bus between a loader and spc_cfg_receiver.
// Carries the serial data in and the loaded word and status out.
interface spc_cfg_receiver_if #(
  parameter int WIDTH = 11
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             Cfg_in;
  logic [WIDTH-1:0] Cfg_word;
  logic             Cfg_done;
  logic             Cfg_err;
  logic [CW-1:0]    Bit_cnt;

  modport master (
    output Cfg_in,
    input  Cfg_word,
    input  Cfg_done,
    input  Cfg_err,
    input  Bit_cnt
  );

  modport slave (
    input  Cfg_in,
    output Cfg_word,
    output Cfg_done,
    output Cfg_err,
    output Bit_cnt
  );
endinterface

// File: rtl/spc_cfg_receiver.sv
// Serial LSB-first configuration word receiver.
// Loads one word after reset; extra edges only raise a sticky overrun flag.
module spc_cfg_receiver #(
  parameter int               WIDTH       = 11,
  parameter logic [WIDTH-1:0] CFG_DEFAULT = '0
) (
  input logic              Clk,
  input logic              Resetn,
  spc_cfg_receiver_if.slave cfg
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    RX     = 2'd0,
    LOADED = 2'd1,
    OVF    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  // The final bit comes straight from Cfg_in, so WIDTH-1 stored bits suffice
  logic [WIDTH-2:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= RX;
      sreg_q  <= '0;
      cnt_q   <= '0;
      word_q  <= CFG_DEFAULT;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      RX: begin
        sreg_d = {cfg.Cfg_in, sreg_q[WIDTH-2:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          word_d  = {cfg.Cfg_in, sreg_q};
          done_d  = 1'b1;
          state_d = LOADED;
        end
      end
      LOADED: begin
        err_d   = 1'b1;
        state_d = OVF;
      end
      OVF: begin
        state_d = OVF;
      end
      default: begin
        state_d = RX;
      end
    endcase
  end

  assign cfg.Cfg_word = word_q;
  assign cfg.Cfg_done = done_q;
  assign cfg.Cfg_err  = err_q;
  assign cfg.Bit_cnt  = cnt_q;
endmodule
